// File: rtl/tri_setup_pkg.sv
// Shared types and width helpers for triangle setup and the rasteriser.
package tri_setup_pkg;

  function automatic int unsigned aw_of(input int unsigned cw);
    return cw + 1;
  endfunction

  function automatic int unsigned kw_of(input int unsigned cw);
    return 2 * cw + 2;
  endfunction

  function automatic int unsigned sw_of(input int unsigned cw);
    return 2 * cw + 4;
  endfunction

  localparam int unsigned CW_DEF = 10;
  localparam int unsigned AW_DEF = aw_of(CW_DEF);
  localparam int unsigned KW_DEF = kw_of(CW_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FINAL,
    ST_HOLD
  } state_t;

  // One edge equation at the default coordinate width.
  typedef struct packed {
    logic signed [AW_DEF-1:0] a;
    logic signed [AW_DEF-1:0] b;
    logic signed [KW_DEF-1:0] c;
  } edge_res_t;

endpackage

// File: rtl/edge_coeff.sv
// Pipelined edge-equation unit: a, b, c for one vertex pair, MUL_LAT+1 cycles issue to retire.
module edge_coeff
  import tri_setup_pkg::*;
#(
  parameter int unsigned CW      = 10,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    issue,
  input  logic [1:0]              tag,
  input  logic [CW-1:0]           xi,
  input  logic [CW-1:0]           yi,
  input  logic [CW-1:0]           xj,
  input  logic [CW-1:0]           yj,
  output logic                    retire,
  output logic [1:0]              rtag,
  output logic [aw_of(CW)-1:0]    a,
  output logic [aw_of(CW)-1:0]    b,
  output logic [kw_of(CW)-1:0]    c
);

  localparam int unsigned AW = aw_of(CW);
  localparam int unsigned KW = kw_of(CW);
  localparam int unsigned PW = 2 * CW;
  localparam int unsigned L  = MUL_LAT - 1;

  logic          m_v   [MUL_LAT];
  logic [1:0]    m_tag [MUL_LAT];
  logic [AW-1:0] m_a   [MUL_LAT];
  logic [AW-1:0] m_b   [MUL_LAT];
  logic [PW-1:0] m_p0  [MUL_LAT];
  logic [PW-1:0] m_p1  [MUL_LAT];

  // Products enter stage 0; extra stages give the multiplier room to retime.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < int'(MUL_LAT); k++) begin
        m_v[k]   <= 1'b0;
        m_tag[k] <= '0;
        m_a[k]   <= '0;
        m_b[k]   <= '0;
        m_p0[k]  <= '0;
        m_p1[k]  <= '0;
      end
      retire <= 1'b0;
      rtag   <= '0;
      a      <= '0;
      b      <= '0;
      c      <= '0;
    end else begin
      m_v[0]   <= issue;
      m_tag[0] <= tag;
      m_a[0]   <= {1'b0, yi} - {1'b0, yj};
      m_b[0]   <= {1'b0, xj} - {1'b0, xi};
      m_p0[0]  <= PW'(xi) * PW'(yj);
      m_p1[0]  <= PW'(xj) * PW'(yi);
      for (int k = 1; k < int'(MUL_LAT); k++) begin
        m_v[k]   <= m_v[k-1];
        m_tag[k] <= m_tag[k-1];
        m_a[k]   <= m_a[k-1];
        m_b[k]   <= m_b[k-1];
        m_p0[k]  <= m_p0[k-1];
        m_p1[k]  <= m_p1[k-1];
      end
      retire <= m_v[L];
      rtag   <= m_tag[L];
      a      <= m_a[L];
      b      <= m_b[L];
      c      <= KW'(m_p0[L]) - KW'(m_p1[L]);
    end
  end

endmodule

// File: rtl/tri_edge_setup.sv
// Triangle setup: three edge equations and twice the signed area, with optional winding normalisation.
module tri_edge_setup
  import tri_setup_pkg::*;
#(
  parameter int unsigned CW        = 10,
  parameter int unsigned MUL_LAT   = 2,
  parameter bit          NORMALISE = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        x0,
  input  logic [CW-1:0]        y0,
  input  logic [CW-1:0]        x1,
  input  logic [CW-1:0]        y1,
  input  logic [CW-1:0]        x2,
  input  logic [CW-1:0]        y2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [aw_of(CW)-1:0] a0,
  output logic [aw_of(CW)-1:0] b0,
  output logic [aw_of(CW)-1:0] a1,
  output logic [aw_of(CW)-1:0] b1,
  output logic [aw_of(CW)-1:0] a2,
  output logic [aw_of(CW)-1:0] b2,
  output logic [kw_of(CW)-1:0] c0,
  output logic [kw_of(CW)-1:0] c1,
  output logic [kw_of(CW)-1:0] c2,
  output logic [sw_of(CW)-1:0] area2,
  output logic                 degenerate,
  output logic                 flipped
);

  localparam int unsigned AW = aw_of(CW);
  localparam int unsigned KW = kw_of(CW);
  localparam int unsigned SW = sw_of(CW);

  state_t        state, state_nx;
  logic [1:0]    idx;
  logic          issue;
  logic          accept;
  logic [CW-1:0] vx0, vy0, vx1, vy1, vx2, vy2;
  logic [CW-1:0] xi, yi, xj, yj;
  logic          ret;
  logic [1:0]    rtag;
  logic [AW-1:0] ra, rb;
  logic [KW-1:0] rc;
  logic [AW-1:0] ea [3];
  logic [AW-1:0] eb [3];
  logic [KW-1:0] ec [3];
  logic [SW-1:0] area_c;
  logic          neg_c;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_ISSUE;
      ST_ISSUE: begin
        issue = 1'b1;
        if (idx == 2'd2) state_nx = ST_DRAIN;
      end
      ST_DRAIN: if (ret && rtag == 2'd2) state_nx = ST_FINAL;
      ST_FINAL: state_nx = ST_HOLD;
      ST_HOLD:  if (out_ready) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Edge i pairs vertex i with vertex (i+1) mod 3.
  always_comb begin
    xi = vx0; yi = vy0; xj = vx1; yj = vy1;
    case (idx)
      2'd1:    begin xi = vx1; yi = vy1; xj = vx2; yj = vy2; end
      2'd2:    begin xi = vx2; yi = vy2; xj = vx0; yj = vy0; end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx <= '0;
      vx0 <= '0; vy0 <= '0; vx1 <= '0; vy1 <= '0; vx2 <= '0; vy2 <= '0;
    end else begin
      idx <= (state == ST_ISSUE) ? idx + 2'd1 : 2'd0;
      if (accept) begin
        vx0 <= x0; vy0 <= y0; vx1 <= x1; vy1 <= y1; vx2 <= x2; vy2 <= y2;
      end
    end
  end

  edge_coeff #(
    .CW      (CW),
    .MUL_LAT (MUL_LAT)
  ) u_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .issue   (issue),
    .tag     (idx),
    .xi      (xi),
    .yi      (yi),
    .xj      (xj),
    .yj      (yj),
    .retire  (ret),
    .rtag    (rtag),
    .a       (ra),
    .b       (rb),
    .c       (rc)
  );

  // Capture each edge as it retires, slotted by its tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        ea[k] <= '0;
        eb[k] <= '0;
        ec[k] <= '0;
      end
    end else if (ret) begin
      case (rtag)
        2'd0:    begin ea[0] <= ra; eb[0] <= rb; ec[0] <= rc; end
        2'd1:    begin ea[1] <= ra; eb[1] <= rb; ec[1] <= rc; end
        2'd2:    begin ea[2] <= ra; eb[2] <= rb; ec[2] <= rc; end
        default: ;
      endcase
    end
  end

  always_comb begin
    area_c = {{(SW-KW){ec[0][KW-1]}}, ec[0]}
           + {{(SW-KW){ec[1][KW-1]}}, ec[1]}
           + {{(SW-KW){ec[2][KW-1]}}, ec[2]};
    neg_c  = NORMALISE && area_c[SW-1];
  end

  // Results only change in FINAL; handshake flags follow the next state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      a0 <= '0; b0 <= '0; a1 <= '0; b1 <= '0; a2 <= '0; b2 <= '0;
      c0 <= '0; c1 <= '0; c2 <= '0;
      area2      <= '0;
      degenerate <= 1'b0;
      flipped    <= 1'b0;
    end else begin
      in_ready  <= (state_nx == ST_IDLE);
      out_valid <= (state_nx == ST_HOLD);
      if (state == ST_FINAL) begin
        a0 <= neg_c ? -ea[0] : ea[0];
        b0 <= neg_c ? -eb[0] : eb[0];
        a1 <= neg_c ? -ea[1] : ea[1];
        b1 <= neg_c ? -eb[1] : eb[1];
        a2 <= neg_c ? -ea[2] : ea[2];
        b2 <= neg_c ? -eb[2] : eb[2];
        c0 <= neg_c ? -ec[0] : ec[0];
        c1 <= neg_c ? -ec[1] : ec[1];
        c2 <= neg_c ? -ec[2] : ec[2];
        area2      <= neg_c ? -area_c : area_c;
        degenerate <= (area_c == '0);
        flipped    <= neg_c;
      end
    end
  end

endmodule

// File: tb/tb_tri_edge_setup.sv
// Directed bench for tri_edge_setup: normalising instance plus a pass-through instance in lockstep.
module tb_tri_edge_setup;
  import tri_setup_pkg::*;

  localparam int unsigned CW = CW_DEF;
  localparam int unsigned AW = aw_of(CW);
  localparam int unsigned KW = kw_of(CW);
  localparam int unsigned SW = sw_of(CW);

  logic clock = 1'b0;
  logic reset_n, in_valid, out_ready;
  logic [CW-1:0] x0, y0, x1, y1, x2, y2;

  logic in_ready, out_valid, degenerate, flipped;
  logic [AW-1:0] a0, b0, a1, b1, a2, b2;
  logic [KW-1:0] c0, c1, c2;
  logic [SW-1:0] area2;

  logic r_in_ready, r_out_valid, r_degenerate, r_flipped;
  logic [AW-1:0] r_a0, r_b0, r_a1, r_b1, r_a2, r_b2;
  logic [KW-1:0] r_c0, r_c1, r_c2;
  logic [SW-1:0] r_area2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_acc = 0;
  edge_res_t exp_e [3];
  int exp_area;
  bit exp_deg, exp_flip;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  tri_edge_setup #(.CW(CW), .MUL_LAT(2), .NORMALISE(1'b1)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .out_valid(out_valid), .out_ready(out_ready),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .a2(a2), .b2(b2),
    .c0(c0), .c1(c1), .c2(c2), .area2(area2),
    .degenerate(degenerate), .flipped(flipped)
  );

  tri_edge_setup #(.CW(CW), .MUL_LAT(2), .NORMALISE(1'b0)) dut_raw (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r_in_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .out_valid(r_out_valid), .out_ready(out_ready),
    .a0(r_a0), .b0(r_b0), .a1(r_a1), .b1(r_b1), .a2(r_a2), .b2(r_b2),
    .c0(r_c0), .c1(r_c1), .c2(r_c2), .area2(r_area2),
    .degenerate(r_degenerate), .flipped(r_flipped)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy);
    x0 = CW'(ax); y0 = CW'(ay);
    x1 = CW'(bx); y1 = CW'(by);
    x2 = CW'(cx); y2 = CW'(cy);
  endtask

  task automatic set_exp(input int ea0, input int eb0, input int ec0,
                         input int ea1, input int eb1, input int ec1,
                         input int ea2, input int eb2, input int ec2,
                         input int ar, input bit dg, input bit fl);
    exp_e[0].a = AW'(ea0); exp_e[0].b = AW'(eb0); exp_e[0].c = KW'(ec0);
    exp_e[1].a = AW'(ea1); exp_e[1].b = AW'(eb1); exp_e[1].c = KW'(ec1);
    exp_e[2].a = AW'(ea2); exp_e[2].b = AW'(eb2); exp_e[2].c = KW'(ec2);
    exp_area = ar;
    exp_deg  = dg;
    exp_flip = fl;
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send();
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (in_ready) begin
        @(posedge clock);
        #1 t_acc = cyc;
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk("accept", longint'(ok), 1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      if (out_valid) begin
        lat = cyc - t_acc;
        break;
      end
      @(negedge clock);
    end
    chk({tag, ".latency"}, lat, 7);
  endtask

  task automatic check_out(input string tag, input bit raw);
    logic [AW-1:0] ga [3];
    logic [AW-1:0] gb [3];
    logic [KW-1:0] gc [3];
    logic [SW-1:0] gar;
    logic gd, gf;
    if (!raw) begin
      ga[0] = a0; gb[0] = b0; gc[0] = c0;
      ga[1] = a1; gb[1] = b1; gc[1] = c1;
      ga[2] = a2; gb[2] = b2; gc[2] = c2;
      gar = area2; gd = degenerate; gf = flipped;
    end else begin
      ga[0] = r_a0; gb[0] = r_b0; gc[0] = r_c0;
      ga[1] = r_a1; gb[1] = r_b1; gc[1] = r_c1;
      ga[2] = r_a2; gb[2] = r_b2; gc[2] = r_c2;
      gar = r_area2; gd = r_degenerate; gf = r_flipped;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.a%0d", tag, i), $signed(ga[i]), exp_e[i].a);
      chk($sformatf("%s.b%0d", tag, i), $signed(gb[i]), exp_e[i].b);
      chk($sformatf("%s.c%0d", tag, i), $signed(gc[i]), exp_e[i].c);
    end
    chk({tag, ".area2"}, $signed(gar), exp_area);
    chk({tag, ".degenerate"}, longint'(gd), longint'(exp_deg));
    chk({tag, ".flipped"}, longint'(gf), longint'(exp_flip));
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk({tag, ".drop"}, longint'(out_valid), 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_tri(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    chk("rst.in_ready", longint'(in_ready), 1);
    chk("rst.out_valid", longint'(out_valid), 0);
    chk("rst.area2", $signed(area2), 0);
    chk("rst.c0", $signed(c0), 0);
    chk("rst.flipped", longint'(flipped), 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Counter-clockwise triangle.
    set_tri(249, 116, 347, 247, 313, 267);
    send();
    wait_out("ccw");
    set_exp(-131, 98, 21251, -20, -34, 15338, 151, -64, -30175, 6414, 1'b0, 1'b0);
    check_out("ccw", 1'b0);
    consume("ccw");

    // Clockwise: normalised vs pass-through instance.
    set_tri(249, 116, 313, 267, 347, 247);
    send();
    wait_out("cw");
    set_exp(151, -64, -30175, -20, -34, 15338, -131, 98, 21251, 6414, 1'b0, 1'b1);
    check_out("cw", 1'b0);
    set_exp(-151, 64, 30175, 20, 34, -15338, 131, -98, -21251, -6414, 1'b0, 1'b0);
    check_out("cw_raw", 1'b1);
    consume("cw");

    // Collinear.
    set_tri(0, 0, 10, 10, 20, 20);
    send();
    wait_out("line");
    set_exp(-10, 10, 0, -10, 10, 0, 20, -20, 0, 0, 1'b1, 1'b0);
    check_out("line", 1'b0);
    consume("line");

    // Extreme coordinates, then backpressure with a second triple queued.
    set_tri(1023, 0, 0, 1023, 0, 0);
    send();
    wait_out("ext");
    set_exp(-1023, -1023, 1046529, 1023, 0, 0, 0, 1023, 0, 1046529, 1'b0, 1'b0);
    check_out("ext", 1'b0);
    set_tri(249, 116, 347, 247, 313, 267);
    in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      chk("bp.in_ready", longint'(in_ready), 0);
      chk("bp.out_valid", longint'(out_valid), 1);
      chk("bp.area2", $signed(area2), 1046529);
    end
    check_out("bp_hold", 1'b0);
    consume("bp");
    send();
    wait_out("bp2");
    set_exp(-131, 98, 21251, -20, -34, 15338, 151, -64, -30175, 6414, 1'b0, 1'b0);
    check_out("bp2", 1'b0);
    consume("bp2");

    // Reset while edges are draining.
    set_tri(0, 0, 10, 10, 20, 20);
    send();
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rstmid.out_valid", longint'(out_valid), 0);
    chk("rstmid.a0", $signed(a0), 0);
    chk("rstmid.c1", $signed(c1), 0);
    chk("rstmid.area2", $signed(area2), 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) @(negedge clock);
    chk("rstmid.in_ready", longint'(in_ready), 1);
    chk("rstmid.no_out", longint'(out_valid), 0);
    set_tri(249, 116, 347, 247, 313, 267);
    send();
    wait_out("post");
    set_exp(-131, 98, 21251, -20, -34, 15338, 151, -64, -30175, 6414, 1'b0, 1'b0);
    check_out("post", 1'b0);
    consume("post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
